rgb_to_gray_converter: RTL

//  Upstream stage of the Sobel filter: converts a UART byte stream of RGB888 pixels into
//  the 8-bit grayscale stream the Sobel stage consumes. Forwards the 4-byte frame header
//  (width LE, height LE) unchanged, then emits one luma byte per 3 input bytes (R,G,B).

---
 rtl/rgb_to_gray_converter_if.sv | 21 ++
 rtl/rgb_to_gray_converter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rgb_to_gray_converter_if.sv
// rtl/rgb_to_gray_converter_if.sv - byte stream handshake bundle: UART side in, Sobel side out
interface rgb_to_gray_converter_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_in;
  logic                 valid_in;
  logic                 ready_in;
  logic [DATA_BITS-1:0] data_out;
  logic                 valid_out;
  logic                 ready_out;

  modport slave (
    input  data_in, valid_in, ready_out,
    output ready_in, data_out, valid_out
  );

  modport master (
    output data_in, valid_in, ready_out,
    input  ready_in, data_out, valid_out
  );
endinterface

// File: rtl/rgb_to_gray_converter.sv
// rtl/rgb_to_gray_converter.sv - RGB888 byte stream to luma byte stream, frame header forwarded
module rgb_to_gray_converter #(
  parameter int DATA_BITS = 8,
  parameter int COEF_R    = 77,
  parameter int COEF_G    = 150,
  parameter int COEF_B    = 29
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  rgb_to_gray_converter_if.slave s_if,
  output logic                   o_frame_done,
  output logic                   o_overrun
);
  localparam int HW = 2 * DATA_BITS;
  localparam int TW = 4 * DATA_BITS;
  localparam int SW = 2 * DATA_BITS;

  typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_PIXEL, ST_DONE} state_t;
  typedef enum logic [1:0] {CH_R, CH_G, CH_B} chan_t;

  state_t               r_state;
  state_t               w_state_nxt;
  chan_t                r_chan;
  logic [1:0]           r_hdr_cnt;
  logic [HW-1:0]        r_width;
  logic [DATA_BITS-1:0] r_height_lo;
  logic [TW-1:0]        r_pix_total;
  logic [TW-1:0]        r_pix_cnt;
  logic [DATA_BITS-1:0] r_red;
  logic [DATA_BITS-1:0] r_green;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_valid_out;
  logic                 r_frame_done;
  logic                 r_overrun;

  logic                 w_ready_in;
  logic                 w_accept;
  logic                 w_drop;
  logic                 w_drain;
  logic [HW-1:0]        w_height_full;
  logic [TW-1:0]        w_total;
  logic [TW-1:0]        w_pix_next;
  logic [SW-1:0]        w_sum;
  logic                 w_load;
  logic                 w_done_pulse;
  logic [DATA_BITS-1:0] w_load_data;

  // The output register may drain and reload in the same cycle, giving 1 byte/clk.
  assign w_ready_in    = (r_state != ST_DONE) && (!r_valid_out || s_if.ready_out);
  assign w_accept      = s_if.valid_in && w_ready_in;
  assign w_drop        = s_if.valid_in && !w_ready_in;
  assign w_drain       = r_valid_out && s_if.ready_out;
  assign w_height_full = {s_if.data_in, r_height_lo};
  assign w_total       = TW'(r_width) * TW'(w_height_full);
  assign w_pix_next    = r_pix_cnt + TW'(1);
  assign w_sum         = SW'(COEF_R) * SW'(r_red)
                       + SW'(COEF_G) * SW'(r_green)
                       + SW'(COEF_B) * SW'(s_if.data_in);

  assign s_if.ready_in  = w_ready_in;
  assign s_if.data_out  = r_data_out;
  assign s_if.valid_out = r_valid_out;
  assign o_frame_done   = r_frame_done;
  assign o_overrun      = r_overrun;

  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_load_data  = s_if.data_in;
    w_done_pulse = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_load      = 1'b1;
          w_state_nxt = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (w_accept) begin
          w_load = 1'b1;
          if (r_hdr_cnt == 2'd3) begin
            w_state_nxt = (w_total == '0) ? ST_DONE : ST_PIXEL;
          end
        end
      end
      ST_PIXEL: begin
        if (w_accept && r_chan == CH_B) begin
          w_load      = 1'b1;
          w_load_data = w_sum[SW-1:DATA_BITS];
          if (w_pix_next == r_pix_total) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      default: begin
        if (!r_valid_out) begin
          w_done_pulse = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_chan       <= CH_R;
      r_hdr_cnt    <= '0;
      r_width      <= '0;
      r_height_lo  <= '0;
      r_pix_total  <= '0;
      r_pix_cnt    <= '0;
      r_red        <= '0;
      r_green      <= '0;
      r_data_out   <= '0;
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= w_done_pulse;

      if (w_load) begin
        r_data_out  <= w_load_data;
        r_valid_out <= 1'b1;
      end else if (w_drain) begin
        r_valid_out <= 1'b0;
      end

      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (r_state == ST_IDLE && w_accept) begin
        r_overrun <= 1'b0;
      end

      if (w_accept) begin
        case (r_state)
          ST_IDLE: begin
            r_width[DATA_BITS-1:0] <= s_if.data_in;
            r_hdr_cnt              <= 2'd1;
          end
          ST_HEADER: begin
            r_hdr_cnt <= r_hdr_cnt + 2'd1;
            case (r_hdr_cnt)
              2'd1:    r_width[HW-1:DATA_BITS] <= s_if.data_in;
              2'd2:    r_height_lo             <= s_if.data_in;
              default: begin
                r_pix_total <= w_total;
                r_pix_cnt   <= '0;
                r_chan      <= CH_R;
              end
            endcase
          end
          ST_PIXEL: begin
            case (r_chan)
              CH_R: begin
                r_red  <= s_if.data_in;
                r_chan <= CH_G;
              end
              CH_G: begin
                r_green <= s_if.data_in;
                r_chan  <= CH_B;
              end
              default: begin
                r_chan    <= CH_R;
                r_pix_cnt <= w_pix_next;
              end
            endcase
          end
          default: begin
          end
        endcase
      end
    end
  end
endmodule
